// File: rtl/audio_pkg.sv
// audio_pkg: shared audio defaults and the stereo sample type
package audio_pkg;
   localparam int AUD_BIT_DEPTH = 24;
   localparam int SLOT_BITS     = 32;
   localparam int BCLK_DIV      = 6;
   typedef struct packed {
      logic signed [AUD_BIT_DEPTH-1:0] l;
      logic signed [AUD_BIT_DEPTH-1:0] r;
   } stereo_sample_t;
endpackage

// File: rtl/audio_i2s_tx_if.sv
// audio_i2s_tx_if: stereo sample valid/ready handshake from synthesizer to I2S transmitter
interface audio_i2s_tx_if
   import audio_pkg::*;
#(
   parameter int W = AUD_BIT_DEPTH
);
   logic [W-1:0] lsound_in;
   logic [W-1:0] rsound_in;
   logic         sample_valid;
   logic         sample_ready;
   modport master (output lsound_in, rsound_in, sample_valid, input sample_ready);
   modport slave  (input lsound_in, rsound_in, sample_valid, output sample_ready);
endinterface

// File: rtl/audio_sample_buf.sv
// audio_sample_buf: one-entry valid/ready holding register emptied by a frame load
module audio_sample_buf
   import audio_pkg::*;
#(
   parameter type T = stereo_sample_t
) (
   input  logic clk,
   input  logic rst,
   input  T     din,
   input  logic valid,
   output logic ready,
   input  logic load,
   output T     dout,
   output logic full
);
   T     data_d, data_q;
   logic full_d, full_q, ready_d, ready_q, accept;
   always_comb begin
      accept  = valid && ready_q;
      data_d  = accept ? din : data_q;
      full_d  = accept ? 1'b1 : load ? 1'b0 : full_q;
      ready_d = !full_d;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         data_q  <= '0;
         full_q  <= 1'b0;
         ready_q <= 1'b0;
      end else begin
         data_q  <= data_d;
         full_q  <= full_d;
         ready_q <= ready_d;
      end
   end
   assign ready = ready_q;
   assign dout  = data_q;
   assign full  = full_q;
endmodule

// File: rtl/audio_i2s_tx.sv
// audio_i2s_tx: serializes buffered stereo pairs into I2S with generated BCLK and LRCK
module audio_i2s_tx #(
   parameter int AUD_BIT_DEPTH = audio_pkg::AUD_BIT_DEPTH,
   parameter int SLOT_BITS     = audio_pkg::SLOT_BITS,
   parameter int BCLK_DIV      = audio_pkg::BCLK_DIV
) (
   input  logic          AUDIO_CLK,
   input  logic          reset_data,
   audio_i2s_tx_if.slave snd,
   output logic          AUD_BCLK,
   output logic          AUD_DACLRCK,
   output logic          AUD_DACDAT,
   output logic          frame_start,
   output logic          underrun
);
   localparam int BW = $clog2(2 * SLOT_BITS);
   localparam int DW = $clog2(BCLK_DIV);
   localparam logic [DW-1:0] DIV_LAST = DW'(BCLK_DIV - 1);
   localparam logic [DW-1:0] DIV_HALF = DW'(BCLK_DIV / 2);
   localparam logic [BW-1:0] BIT_LAST = BW'(2 * SLOT_BITS - 1);
   localparam logic [BW-1:0] SLOT     = BW'(SLOT_BITS);
   localparam logic [BW-1:0] DEPTH    = BW'(AUD_BIT_DEPTH);
   typedef struct packed {
      logic [AUD_BIT_DEPTH-1:0] l;
      logic [AUD_BIT_DEPTH-1:0] r;
   } pair_t;
   pair_t                    in_pair, buf_pair, pair_d, pair_q;
   logic                     buf_full, wrap, load;
   logic [DW-1:0]            div_cnt_d, div_cnt_q;
   logic [BW-1:0]            bit_cnt_d, bit_cnt_q, nb, p;
   logic [AUD_BIT_DEPTH-1:0] sh_d, sh_q;
   logic                     bclk_d, bclk_q, lrck_d, lrck_q, dat_d, dat_q, fs_d, fs_q, ur_d, ur_q;
   assign in_pair = {snd.lsound_in, snd.rsound_in};
   audio_sample_buf #(.T(pair_t)) u_buf (
      .clk   (AUDIO_CLK),
      .rst   (reset_data),
      .din   (in_pair),
      .valid (snd.sample_valid),
      .ready (snd.sample_ready),
      .load  (load),
      .dout  (buf_pair),
      .full  (buf_full)
   );
   // pair_q doubles as the last-loaded pair, so an empty buffer simply keeps it
   always_comb begin
      wrap      = div_cnt_q == DIV_LAST;
      load      = wrap && bit_cnt_q == BIT_LAST;
      nb        = (bit_cnt_q == BIT_LAST) ? '0 : bit_cnt_q + BW'(1);
      p         = (nb >= SLOT) ? nb - SLOT : nb;
      div_cnt_d = wrap ? '0 : div_cnt_q + DW'(1);
      bit_cnt_d = wrap ? nb : bit_cnt_q;
      pair_d    = (load && buf_full) ? buf_pair : pair_q;
      sh_d      = !wrap ? sh_q :
                  (p == '0) ? ((nb < SLOT) ? pair_d.l : pair_q.r) :
                  (p <= DEPTH) ? sh_q << 1 : sh_q;
      dat_d     = !wrap ? dat_q : (p != '0) && (p <= DEPTH) && sh_q[AUD_BIT_DEPTH-1];
      lrck_d    = wrap ? (nb >= SLOT) : lrck_q;
      bclk_d    = (div_cnt_d == DIV_HALF) ? 1'b1 : wrap ? 1'b0 : bclk_q;
      fs_d      = load;
      ur_d      = load && !buf_full;
   end
   always_ff @(posedge AUDIO_CLK) begin
      if (reset_data) begin
         {div_cnt_q, bit_cnt_q, pair_q, sh_q} <= '0;
         {bclk_q, lrck_q, dat_q, fs_q, ur_q}  <= '0;
      end else begin
         div_cnt_q <= div_cnt_d;
         bit_cnt_q <= bit_cnt_d;
         pair_q    <= pair_d;
         sh_q      <= sh_d;
         bclk_q    <= bclk_d;
         lrck_q    <= lrck_d;
         dat_q     <= dat_d;
         fs_q      <= fs_d;
         ur_q      <= ur_d;
      end
   end
   assign AUD_BCLK    = bclk_q;
   assign AUD_DACLRCK = lrck_q;
   assign AUD_DACDAT  = dat_q;
   assign frame_start = fs_q;
   assign underrun    = ur_q;
endmodule

// File: tb/tb_audio_i2s_tx.sv
// tb_audio_i2s_tx: directed checks of I2S framing, buffering, underrun and reset behaviour
module tb_audio_i2s_tx;
   logic clk, rst, bclk, lrck, dat, fs, ur;
   int tests = 0, failed = 0, n = 0, ur_cnt = 0, fs_cnt = 0, hi = 0;
   logic [63:0] frames[$];
   logic [63:0] rx;
   logic lp, bp;
   typedef struct {
      logic [23:0] l, r;
      logic [31:0] lw, rw;
   } vec_t;
   vec_t tab[8];

   audio_i2s_tx_if #(.W(24)) snd ();
   audio_i2s_tx dut (
      .AUDIO_CLK   (clk),
      .reset_data  (rst),
      .snd         (snd),
      .AUD_BCLK    (bclk),
      .AUD_DACLRCK (lrck),
      .AUD_DACDAT  (dat),
      .frame_start (fs),
      .underrun    (ur)
   );

   initial begin
      clk = 0;
      forever #5 clk = ~clk;
   end

   // receiver: sample DACDAT on each BCLK rise, emit a 64-bit frame when LRCK returns to left
   always @(negedge clk) begin
      if (rst) begin
         lp <= 1'b0;
         bp <= 1'b0;
         rx <= '0;
      end else begin
         if (bclk && !bp) begin
            if (lp && !lrck) frames.push_back(rx);
            rx <= {rx[62:0], dat};
            lp <= lrck;
         end
         bp <= bclk;
      end
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         failed++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      n++;
      if (ur) ur_cnt++;
      if (fs) fs_cnt++;
   endtask

   task automatic do_reset();
      rst = 1;
      snd.sample_valid = 0;
      tick();
      tick();
      frames.delete();
      rst = 0;
      n = 0;
      fs_cnt = 0;
      ur_cnt = 0;
   endtask

   task automatic feed(input int i);
      snd.lsound_in = tab[i].l;
      snd.rsound_in = tab[i].r;
      snd.sample_valid = 1;
   endtask

   task automatic wait_fs();
      int k = 0;
      do begin
         tick();
         k++;
      end while (!fs && k < 400);
      if (!fs) begin
         tests++;
         failed++;
         $display("FAIL wait_fs: frame_start absent after %0d cycles, expected within 400", k);
      end
   endtask

   initial begin
      rst = 1;
      snd.sample_valid = 0;
      snd.lsound_in = '0;
      snd.rsound_in = '0;
      tab[0] = '{24'h800001, 24'h7FFFFE, 32'h40000080, 32'h3FFFFF00};
      tab[1] = '{24'h123456, 24'h000000, 32'h091A2B00, 32'h00000000};
      tab[2] = '{24'hFFFFFF, 24'h000001, 32'h7FFFFF80, 32'h00000080};
      tab[3] = '{24'h000000, 24'hFFFFFF, 32'h00000000, 32'h7FFFFF80};
      tab[4] = '{24'hA5A5A5, 24'h5A5A5A, 32'h52D2D280, 32'h2D2D2D00};
      tab[5] = '{24'h7FFFFF, 24'h800000, 32'h3FFFFF80, 32'h40000000};
      tab[6] = '{24'h000100, 24'h010000, 32'h00008000, 32'h00800000};
      tab[7] = '{24'hC0FFEE, 24'h00BEEF, 32'h607FF700, 32'h005F7780};

      do_reset();
      chk("reset_state", {bclk, lrck, dat, fs, ur, snd.sample_ready}, 6'b0);
      for (int k = 1; k <= 384; k++) begin
         tick();
         chk($sformatf("idle_c%0d", k), {bclk, lrck, dat, fs, ur, snd.sample_ready},
             {k % 6 >= 3, k >= 192 && k < 384, 1'b0, k == 384, k == 384, 1'b1});
      end

      do_reset();
      tick();
      chk("ready_after_release", snd.sample_ready, 1'b1);
      feed(0);
      tick();
      chk("ready_low_after_accept", snd.sample_ready, 1'b0);
      feed(1);
      hi = 0;
      for (int k = 3; k <= 383; k++) begin
         tick();
         if (snd.sample_ready) hi++;
      end
      chk("ready_held_low", hi, 0);
      tick();
      chk("load_edge", {snd.sample_ready, fs, ur, lrck}, 4'b1100);
      tick();
      chk("second_accept", snd.sample_ready, 1'b0);
      snd.sample_valid = 0;
      fs_cnt = 0;
      ur_cnt = 0;
      while (n < 1540) begin
         tick();
         if (n == 389) chk("delay_bit", dat, 1'b0);
         if (n == 390) chk("first_msb", dat, 1'b1);
         if (n == 768) chk("second_frame_start", {fs, ur}, 2'b10);
      end
      chk("fs_count", fs_cnt, 3);
      chk("underrun_count", ur_cnt, 2);
      chk("frame_count", frames.size(), 4);
      chk("frame0_zero", frames[0], 64'h0);
      chk("frame1_pair0", frames[1], {tab[0].lw, tab[0].rw});
      chk("frame2_pair1", frames[2], {tab[1].lw, tab[1].rw});
      chk("frame3_repeat", frames[3], {tab[1].lw, tab[1].rw});

      do_reset();
      tick();
      feed(2);
      tick();
      snd.sample_valid = 0;
      while (n < 384) tick();
      feed(3);
      tick();
      snd.sample_valid = 0;
      while (n < 624) tick();
      chk("full_before_reset", {snd.sample_ready, lrck}, 2'b01);
      rst = 1;
      tick();
      chk("mid_reset_outputs", {bclk, lrck, dat, fs, ur, snd.sample_ready}, 6'b0);
      frames.delete();
      rst = 0;
      n = 0;
      fs_cnt = 0;
      tick();
      chk("ready_after_mid_reset", snd.sample_ready, 1'b1);
      while (n < 383) begin
         tick();
         if (n == 191) chk("restart_lrck_left", lrck, 1'b0);
         if (n == 192) chk("restart_lrck_right", lrck, 1'b1);
      end
      chk("no_early_frame_start", fs_cnt, 0);
      tick();
      chk("restart_boundary", {fs, ur, lrck}, 3'b110);
      repeat (4) tick();
      chk("restart_frame_count", frames.size(), 1);
      chk("restart_frame_zero", frames[0], 64'h0);

      do_reset();
      tick();
      feed(0);
      tick();
      snd.sample_valid = 0;
      ur_cnt = 0;
      for (int i = 1; i < 8; i++) begin
         wait_fs();
         feed(i);
         tick();
         chk($sformatf("b2b_accept%0d", i), snd.sample_ready, 1'b0);
         snd.sample_valid = 0;
      end
      wait_fs();
      chk("b2b_no_underrun", ur_cnt, 0);
      wait_fs();
      repeat (4) tick();
      chk("b2b_frame_count", frames.size(), 9);
      for (int i = 0; i < 8; i++)
         chk($sformatf("b2b_word%0d", i), frames[i+1], {tab[i].lw, tab[i].rw});

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end
endmodule
